arb_req_client: RTL and testbench

//  Requester-side agent for the synchronous round-robin arbiter: one instance per

---
 rtl/arb_req_client.sv | 138 +++++++++++++
 tb/tb_arb_req_client.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_req_client.sv
`default_nettype none
// ============================================================================
//  Module   : arb_req_client
//  Purpose  : Requester-side agent for a round-robin arbiter slot. Buffers
//             local words and drives one bus word per registered grant pulse.
//  Revision : 1.0  initial release
// ============================================================================
module arb_req_client #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DATA_W-1:0]        in_data_i,
    output logic                     req_o,
    input  logic                     gnt_i,
    output logic                     bus_valid_o,
    output logic [DATA_W-1:0]        bus_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     starve_o,
    output logic                     err_spurious_o
);

    localparam int unsigned c_ADDR_W = $clog2(DEPTH);
    localparam int unsigned c_LVL_W  = c_ADDR_W + 1;
    localparam int unsigned c_WAIT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [c_LVL_W-1:0]  c_FULL     = c_LVL_W'(DEPTH);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(WAIT_LIMIT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic [c_ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_LVL_W-1:0]     level_q, level_d;
    logic [c_WAIT_W-1:0]    wait_q, wait_d;
    logic                   starve_q, starve_d;
    logic                   err_q, err_d;
    logic                   bus_valid_q, bus_valid_d;
    logic [DATA_W-1:0]      bus_data_q, bus_data_d;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_last_pop;

    // Full refuses a push even when a pop happens in the same cycle.
    assign in_ready_o = (level_q != c_FULL) & ~rst;
    assign w_push     = in_valid_i & in_ready_o;
    assign w_pop      = gnt_i & (level_q != '0);
    assign w_last_pop = w_pop & (level_q == c_LVL_W'(1));

    // REQ holds exactly when words are buffered, so dropping on the last pop
    // keeps the arbiter from granting a slot with nothing behind it.
    assign req_o = (state_q == S_REQ) & ~w_last_pop;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_push) state_d = S_REQ;
            S_REQ:   if (w_last_pop && !w_push) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        bus_valid_d = 1'b0;
        bus_data_d  = '0;
        if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_pop) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            bus_valid_d = 1'b1;
            bus_data_d  = mem_q[rd_ptr_q];
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        wait_d = wait_q;
        if (!req_o || gnt_i) begin
            wait_d = '0;
        end else if (wait_q != c_WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
        end
        starve_d = starve_q | (wait_d == c_WAIT_MAX);
        err_d    = err_q | (gnt_i & (level_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            wait_q      <= '0;
            starve_q    <= 1'b0;
            err_q       <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
            err_q       <= err_d;
            bus_valid_q <= bus_valid_d;
            bus_data_q  <= bus_data_d;
        end
    end

    // Storage needs no reset: nothing is read before it is written.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= in_data_i;
    end

    assign bus_valid_o    = bus_valid_q;
    assign bus_data_o     = bus_data_q;
    assign level_o        = level_q;
    assign starve_o       = starve_q;
    assign err_spurious_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_req_client.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arb_req_client
//  Purpose  : Directed self-checking bench for arb_req_client, plus a
//             four-client system behind a registered round-robin arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_arb_req_client;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        req;
    logic        gnt;
    logic        bus_valid;
    logic [31:0] bus_data;
    logic [2:0]  level;
    logic        starve;
    logic        err_spurious;

    int n_total;
    int n_bad;

    arb_req_client #(.DATA_W(32), .DEPTH(4), .WAIT_LIMIT(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .req_o          (req),
        .gnt_i          (gnt),
        .bus_valid_o    (bus_valid),
        .bus_data_o     (bus_data),
        .level_o        (level),
        .starve_o       (starve),
        .err_spurious_o (err_spurious)
    );

    // Four-client system sharing one bus.
    logic [3:0]  m_vld, m_rdy, m_req, m_gnt, m_bv, m_stv, m_err;
    logic [31:0] m_din [4];
    logic [31:0] m_bd  [4];
    logic [2:0]  m_lvl [4];
    logic [3:0]  a_gnt, a_sel;
    logic [1:0]  a_ptr, a_ptr_nxt;
    int          exp_seq [4];
    int          sent    [4];
    logic [3:0]  fire;

    for (genvar gi = 0; gi < 4; gi++) begin : g_cli
        arb_req_client #(.DATA_W(32), .DEPTH(4), .WAIT_LIMIT(16)) u_cli (
            .clk            (clk),
            .rst            (rst),
            .in_valid_i     (m_vld[gi]),
            .in_ready_o     (m_rdy[gi]),
            .in_data_i      (m_din[gi]),
            .req_o          (m_req[gi]),
            .gnt_i          (m_gnt[gi]),
            .bus_valid_o    (m_bv[gi]),
            .bus_data_o     (m_bd[gi]),
            .level_o        (m_lvl[gi]),
            .starve_o       (m_stv[gi]),
            .err_spurious_o (m_err[gi])
        );
    end

    always_comb begin
        a_sel     = '0;
        a_ptr_nxt = a_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (m_req[2'(a_ptr + 2'(k))]) begin
                a_sel     = '0;
                a_sel[2'(a_ptr + 2'(k))] = 1'b1;
                a_ptr_nxt = 2'(a_ptr + 2'(k) + 2'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_gnt <= '0;
            a_ptr <= '0;
        end else begin
            a_gnt <= a_sel;
            a_ptr <= a_ptr_nxt;
        end
    end
    assign m_gnt = a_gnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Bus monitor: each client's words must arrive once, in push order.
    always @(negedge clk) begin
        if (!rst && (m_bv != '0)) begin
            check("sys_onehot", 64'($countones(m_bv)), 64'd1);
            for (int c = 0; c < 4; c++) begin
                if (m_bv[c]) begin
                    check("sys_data", 64'(m_bd[c]), 64'({8'(c), 24'(exp_seq[c])}));
                    exp_seq[c] <= exp_seq[c] + 1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; gnt = 1'b0;
        m_vld = '0; fire = '0;
        for (int c = 0; c < 4; c++) begin
            m_din[c] = '0; exp_seq[c] = 0; sent[c] = 0;
        end
        repeat (3) cyc();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_level",    64'(level), 64'd0);
        check("rst_req",      64'(req), 64'd0);
        check("rst_ready_up", 64'(in_ready), 64'd1);
        check("rst_bus",      64'({bus_valid, bus_data}), 64'd0);
        check("rst_flags",    64'({starve, err_spurious}), 64'd0);

        // Single word through: push edge 0, gnt cycle 2, bus cycle 3.
        in_valid = 1'b1; in_data = 32'hA5;
        cyc(); in_valid = 1'b0; #1;
        check("t1_level", 64'(level), 64'd1);
        check("t1_req_c1", 64'(req), 64'd1);
        cyc(); gnt = 1'b1; #1;
        check("t1_req_drop", 64'(req), 64'd0);
        check("t1_bus_early", 64'(bus_valid), 64'd0);
        cyc(); gnt = 1'b0; #1;
        check("t1_bus_valid", 64'(bus_valid), 64'd1);
        check("t1_bus_data", 64'(bus_data), 64'h0A5);
        check("t1_level_0", 64'(level), 64'd0);
        cyc(); #1;
        check("t1_bus_clear", 64'({bus_valid, bus_data}), 64'd0);

        // Fill, refuse the fifth push, then drain in order.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'hD0 + 32'(i); cyc();
        end
        in_data = 32'hEE; #1;
        check("t2_full_level", 64'(level), 64'd4);
        check("t2_full_ready", 64'(in_ready), 64'd0);
        cyc(); in_valid = 1'b0; #1;
        check("t2_no_overflow", 64'(level), 64'd4);
        for (int i = 0; i < 4; i++) begin
            gnt = 1'b1; #1;
            check("t2_req", 64'(req), 64'(i != 3));
            cyc(); gnt = 1'b0; #1;
            check("t2_bus_valid", 64'(bus_valid), 64'd1);
            check("t2_bus_data", 64'(bus_data), 64'(32'hD0 + 32'(i)));
        end
        check("t2_drained", 64'(level), 64'd0);

        // Full with grant and push together: pop only.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'hB0 + 32'(i); cyc();
        end
        in_data = 32'hBF; gnt = 1'b1; #1;
        check("t3_ready", 64'(in_ready), 64'd0);
        cyc(); in_valid = 1'b0; gnt = 1'b0; #1;
        check("t3_level", 64'(level), 64'd3);
        check("t3_bus", 64'(bus_data), 64'h0B0);

        // Push and pop together at level 2.
        gnt = 1'b1; cyc(); gnt = 1'b0; #1;
        check("t4_bus_b1", 64'(bus_data), 64'h0B1);
        check("t4_level2", 64'(level), 64'd2);
        in_valid = 1'b1; in_data = 32'hC0; gnt = 1'b1;
        cyc(); in_valid = 1'b0; #1;
        check("t4_level_hold", 64'(level), 64'd2);
        check("t4_bus_b2", 64'(bus_data), 64'h0B2);
        cyc(); #1;
        check("t4_bus_b3", 64'(bus_data), 64'h0B3);
        cyc(); gnt = 1'b0; #1;
        check("t4_bus_c0", 64'(bus_data), 64'h0C0);
        check("t4_empty", 64'(level), 64'd0);

        // Starvation after 16 waiting cycles, then a spurious grant.
        in_valid = 1'b1; in_data = 32'hE0;
        cyc(); in_valid = 1'b0; #1;
        check("t5_starve_c1", 64'(starve), 64'd0);
        for (int k = 2; k <= 16; k++) cyc();
        #1;
        check("t5_starve_c16", 64'(starve), 64'd0);
        cyc(); #1;
        check("t5_starve_c17", 64'(starve), 64'd1);
        gnt = 1'b1; cyc(); gnt = 1'b0; #1;
        check("t5_bus_e0", 64'(bus_data), 64'h0E0);
        check("t5_starve_sticky", 64'(starve), 64'd1);
        gnt = 1'b1; #1;
        check("t5_req_empty", 64'(req), 64'd0);
        cyc(); gnt = 1'b0; #1;
        check("t5_err", 64'(err_spurious), 64'd1);
        check("t5_no_bus", 64'(bus_valid), 64'd0);
        check("t5_level", 64'(level), 64'd0);

        // Reset mid-operation with a grant pending.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'hF0 + 32'(i); cyc();
        end
        in_valid = 1'b0; gnt = 1'b1; rst = 1'b1; #1;
        check("t6_ready_in_rst", 64'(in_ready), 64'd0);
        cyc(); rst = 1'b0; gnt = 1'b0; #1;
        check("t6_level", 64'(level), 64'd0);
        check("t6_req", 64'(req), 64'd0);
        check("t6_bus", 64'(bus_valid), 64'd0);
        check("t6_flags", 64'({starve, err_spurious}), 64'd0);
        cyc(); #1;
        check("t6_bus_after", 64'(bus_valid), 64'd0);

        // Four clients, five words each, staggered producer rates.
        for (int n = 0; n < 300; n++) begin
            for (int c = 0; c < 4; c++) begin
                m_vld[c] = (sent[c] < 5) && ((n % (c + 1)) == 0);
                m_din[c] = {8'(c), 24'(sent[c])};
            end
            @(negedge clk);
            fire = m_vld & m_rdy;
            @(posedge clk);
            #1;
            for (int c = 0; c < 4; c++) if (fire[c]) sent[c]++;
            if (sent[0] == 5 && sent[1] == 5 && sent[2] == 5 && sent[3] == 5) break;
        end
        m_vld = '0;
        for (int n = 0; n < 60; n++) begin
            if (exp_seq[0] == 5 && exp_seq[1] == 5 && exp_seq[2] == 5 && exp_seq[3] == 5) break;
            cyc();
        end
        for (int c = 0; c < 4; c++) begin
            check("sys_pushed", 64'(sent[c]), 64'd5);
            check("sys_delivered", 64'(exp_seq[c]), 64'd5);
            check("sys_level", 64'(m_lvl[c]), 64'd0);
        end
        check("sys_err", 64'(m_err), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
